dac_spi_tx: RTL
===============

# dac_spi_tx

Dual-channel SPI serializer between the DAC sample-assembly stage and the two-input serial DAC. It accepts one 12-bit left/right sample pair per `data_en` strobe and forms two 16-bit frames, {CTRL, sample}. It shifts both frames out MSB-first, in lockstep, on `dac_dina`/`dac_dinb` with a shared `dac_sclk` and `dac_sync`. It runs in the divided core clock domain, and the upstream pacing logic relies on its fixed, known frame length.

## Interface
- `CTRL`, 4'b0000, control nibble prepended to both channels (bits 15:12 of each frame).
- `GAP_CYCLES`, 2, cycles `dac_sync` is held high after a frame before the next frame is accepted; range 1–15.
- `clk` input 1: core clock; the SPI bit rate is clk/2.
- `reset` input 1: synchronous, active-high.
- `data_en` input 1: one-cycle strobe; sample pair valid.
- `data_left` input 12: left sample; serialized on `dac_dina`.
- `data_right` input 12: right sample; serialized on `dac_dinb`.
- `busy` output 1: high while a frame or gap is in progress.
- `frame_done` output 1: one-cycle pulse on the last gap cycle.
- `overrun` output 1: one-cycle pulse when `data_en` arrives while `busy` is high.
- `dac_sclk` output 1: SPI clock, idles high.
- `dac_sync` output 1: active-low frame sync.
- `dac_dina` output 1: channel A serial data.
- `dac_dinb` output 1: channel B serial data.

## Operation
- Clock and reset: one clock (`clk`); reset is synchronous and active-high.
- Reset values: `busy`=0, `frame_done`=0, `overrun`=0, `dac_sclk`=1, `dac_sync`=1, `dac_dina`=0, `dac_dinb`=0. State is IDLE and the shift registers are 0.
- The state machine has three states: IDLE, SHIFT and GAP.
- IDLE: outputs hold their idle values. If `data_en`=1:
  - latch `shift_a` = {CTRL, `data_left`} and `shift_b` = {CTRL, `data_right`};
  - set bit index = 15 and phase = HI;
  - move to SHIFT.
- SHIFT: each bit takes two cycles.
  - Phase HI: `dac_sclk`=1, and `dac_dina`/`dac_dinb` = `shift_a[15]`/`shift_b[15]`.
  - Phase LO: `dac_sclk`=0, and the data lines hold. The DAC samples on this falling edge.
  - After a LO phase, both shift registers shift left by 1 and the index decrements.
  - After the LO phase of index 0, move to GAP.
  - `dac_sync`=0 throughout SHIFT.
- GAP:
  - `dac_sync`=1, `dac_sclk`=1, and the data lines drive 0.
  - The state lasts GAP_CYCLES cycles.
  - `frame_done`=1 on the final GAP cycle, then the block returns to IDLE.
- `data_en` during SHIFT or GAP is ignored: the latched data is unchanged and `overrun` pulses the next cycle.
- The input samples are latched only at acceptance. Later changes to `data_left`/`data_right` do not affect a frame in flight.
- Bits 11:0 of each frame are the sample, unmodified. There is no arithmetic on the sample data.
- Reset mid-frame: the frame is abandoned, and all outputs take their reset values on the cycle after reset is sampled. A `data_en` coincident with reset is dropped.

## Timing
- All outputs are registered. Acceptance of `data_en` in cycle N gives `dac_sync`=0, `busy`=1 and MSB on the data lines in cycle N+1.
- Frame length:
  - `dac_sync` is low for exactly 32 cycles (N+1 … N+32);
  - 16 falling `dac_sclk` edges occur while `dac_sync` is low;
  - the first falling edge is at N+2 and the last at N+32.
- Busy period:
  - `busy` is high for 32 + GAP_CYCLES cycles (N+1 … N+32+GAP_CYCLES);
  - `frame_done` pulses in cycle N+32+GAP_CYCLES;
  - `busy`=0 in N+33+GAP_CYCLES.
- Back-to-back frames: `data_en` in the first cycle with `busy`=0 is accepted. The minimum strobe spacing is 33+GAP_CYCLES cycles, which is 35 at the default. Upstream pacing must exceed this.
- Data lines change only while `dac_sclk` is high (HI phase entry) and are stable across every falling edge.

## Test plan
- **Single frame:** reset, then `data_en` with left=0xABC, right=0x123 at default params.
  - `dac_dina` is sampled on the 16 falling edges as 0000_1010_1011_1100.
  - `dac_dinb` is sampled as 0000_0001_0010_0011.
  - `dac_sync` is low for 32 cycles, `busy` is high for 34 cycles, and `frame_done` pulses once at N+34.
- **Extremes and CTRL:** CTRL=4'b1011 with left=0xFFF, right=0x000 gives A=1011_1111_1111_1111 and B=1011_0000_0000_0000.
- **Back-to-back:** a second `data_en` in the first cycle `busy`=0 is accepted, and its `dac_sync` falls exactly GAP_CYCLES+1 cycles after the previous rise.
- **Overrun:**
  - `data_en` at N+10 and at N+33 (in GAP) with new data each produces an `overrun` pulse at N+11 and N+34;
  - the frame in flight is unchanged;
  - `busy` drops at N+35.
- **Reset mid-frame:** `reset` at N+15 gives idle outputs at N+16 (`dac_sync`=1, `dac_sclk`=1, `busy`=0), and a fresh `data_en` afterwards produces a complete, correct frame.
- **Input stability:** toggling `data_left`/`data_right` every cycle during SHIFT leaves the serialized bits equal to the values latched at acceptance.

Source files
------------

// File: rtl/dac_spi_tx.sv
// Dual-channel SPI serializer: frames {CTRL, sample} for left/right and shifts both out
// MSB-first in lockstep with a shared clk/2 SCLK and active-low SYNC.
module dac_spi_tx #(
  parameter logic [3:0]  CTRL       = 4'b0000,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_en,
  input  logic [11:0] data_left,
  input  logic [11:0] data_right,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output logic        dac_sclk,
  output logic        dac_sync,
  output logic        dac_dina,
  output logic        dac_dinb
);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  localparam logic [3:0] GapLast = 4'(GAP_CYCLES - 1);

  state_e      state_q;
  logic [15:0] shift_a_q;
  logic [15:0] shift_b_q;
  logic [3:0]  bit_idx_q;
  logic        phase_lo_q;
  logic [3:0]  gap_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_a_q  <= '0;
      shift_b_q  <= '0;
      bit_idx_q  <= '0;
      phase_lo_q <= 1'b0;
      gap_cnt_q  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      dac_sclk   <= 1'b1;
      dac_sync   <= 1'b1;
      dac_dina   <= 1'b0;
      dac_dinb   <= 1'b0;
    end else begin
      overrun <= data_en && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (data_en) begin
            shift_a_q  <= {CTRL, data_left};
            shift_b_q  <= {CTRL, data_right};
            bit_idx_q  <= 4'd15;
            phase_lo_q <= 1'b0;
            state_q    <= StShift;
            busy       <= 1'b1;
            dac_sync   <= 1'b0;
            dac_sclk   <= 1'b1;
            dac_dina   <= CTRL[3];
            dac_dinb   <= CTRL[3];
          end
        end
        StShift: begin
          if (!phase_lo_q) begin
            // Data lines hold so they are stable across the falling edge.
            phase_lo_q <= 1'b1;
            dac_sclk   <= 1'b0;
          end else begin
            shift_a_q  <= {shift_a_q[14:0], 1'b0};
            shift_b_q  <= {shift_b_q[14:0], 1'b0};
            bit_idx_q  <= bit_idx_q - 4'd1;
            phase_lo_q <= 1'b0;
            dac_sclk   <= 1'b1;
            if (bit_idx_q == 4'd0) begin
              state_q    <= StGap;
              gap_cnt_q  <= GapLast;
              dac_sync   <= 1'b1;
              dac_dina   <= 1'b0;
              dac_dinb   <= 1'b0;
              frame_done <= (GAP_CYCLES == 1);
            end else begin
              dac_dina <= shift_a_q[14];
              dac_dinb <= shift_b_q[14];
            end
          end
        end
        StGap: begin
          if (gap_cnt_q == 4'd0) begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            frame_done <= 1'b0;
          end else begin
            gap_cnt_q  <= gap_cnt_q - 4'd1;
            frame_done <= (gap_cnt_q == 4'd1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
